pipeline_freeze_ctl: RTL

PIPELINE_FREEZE_CTL -- requirements
Module: pipeline_freeze_ctl

---
 rtl/pipeline_freeze_ctl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pipeline_freeze_ctl.sv
// Pipeline freeze/bubble controller: hazard, MDU-occupancy and memory-stall arbitration.
// Optional stall-cycle performance counter is built when FREEZE_PERF_EN is defined.
module pipeline_freeze_ctl #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FWD_REQ_FREEZE,
  input  logic        LOAD_USE_REQ,
  input  logic        MDU_START,
  input  logic        MDU_IS_DIV,
  input  logic        MDU_READ,
  input  logic        MEM_STALL,
  output logic        FREEZE_IF,
  output logic        FREEZE_ID,
  output logic        BUBBLE_EXE,
  output logic        FWD_HIST_BUBBLE,
  output logic        FREEZE_ALL,
  output logic        MDU_BUSY,
`ifdef FREEZE_PERF_EN
  output logic [31:0] STALL_CYCLES,
`endif
  output logic [1:0]  STALL_CAUSE
);

  localparam logic [5:0] MULT_LAT_C = 6'(MULT_LAT);
  localparam logic [5:0] DIV_LAT_C  = 6'(DIV_LAT);

  typedef enum logic [1:0] {
    S_RUN = 2'b00,
    S_HAZ = 2'b01,
    S_MDU = 2'b10,
    S_MEM = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] mdu_cnt_q, mdu_cnt_d;
  logic       mdu_hold;
  logic       fwd_haz;
  logic       hazard;

  // A new MDU_START always restarts the occupancy window, even mid-operation.
  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (MDU_START) begin
      mdu_cnt_d = MDU_IS_DIV ? DIV_LAT_C : MULT_LAT_C;
    end else if (mdu_cnt_q != 6'd0) begin
      mdu_cnt_d = mdu_cnt_q - 6'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      mdu_cnt_q <= 6'd0;
    end else begin
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  assign MDU_BUSY = (mdu_cnt_q != 6'd0);
  assign mdu_hold = MDU_READ & MDU_BUSY;
  assign fwd_haz  = FWD_REQ_FREEZE | LOAD_USE_REQ;
  assign hazard   = fwd_haz | mdu_hold;

  // Memory stall freezes everything in place, so no bubble is injected behind it.
  always_comb begin
    FREEZE_IF       = 1'b0;
    FREEZE_ID       = 1'b0;
    BUBBLE_EXE      = 1'b0;
    FWD_HIST_BUBBLE = 1'b0;
    FREEZE_ALL      = 1'b0;
    if (RESET) begin
      if (MEM_STALL) begin
        FREEZE_IF  = 1'b1;
        FREEZE_ID  = 1'b1;
        FREEZE_ALL = 1'b1;
      end else if (hazard) begin
        FREEZE_IF       = 1'b1;
        FREEZE_ID       = 1'b1;
        BUBBLE_EXE      = 1'b1;
        FWD_HIST_BUBBLE = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = S_RUN;
    if (MEM_STALL) begin
      state_d = S_MEM;
    end else if (mdu_hold) begin
      state_d = S_MDU;
    end else if (fwd_haz) begin
      state_d = S_HAZ;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign STALL_CAUSE = state_q;

`ifdef FREEZE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (FREEZE_IF && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign STALL_CYCLES = stall_cnt_q;
`endif

endmodule
